dram_ctrl_resp: RTL and testbench
=================================

Name: dram_ctrl_resp

Overview:
- Single-port DRAM responder for the data cache's block-fill and write-back interface. Serves the other end of that interface.
- Accepts level-held burst requests (dram_rd_req / dram_wr_req) with a word address aligned to a BLOCK_SIZE-word block.
- Returns or absorbs BLOCK_SIZE words, one dram_rd_val / dram_wr_val pulse per word.
- Sits between the D-cache and the word-addressed backing memory array, which is held inside this block.

Parameters:
- MEM_AW, 14: word-address bits used to index the internal memory (2^MEM_AW x 32-bit words).
- BLOCK_SIZE, 8: words per burst; must be a power of 2.
- RD_LATENCY, 4: cycles from the IDLE sample of dram_rd_req to the first dram_rd_val; minimum 1.
- WR_LATENCY, 2: cycles from the IDLE sample of dram_wr_req to the first dram_wr_val; minimum 2.
- BEAT_GAP, 1: idle cycles between consecutive val pulses within a burst; minimum 1.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dram_rd_req  in  1  read burst request, held high until the requester has counted BLOCK_SIZE beats.
- dram_rd_addr  in  32  word address of the burst's first word.
- dram_rd_data  out  32  read word; valid only while dram_rd_val=1.
- dram_rd_val  out  1  one-cycle pulse per read word.
- dram_wr_req  in  1  write burst request, held high until BLOCK_SIZE beats have been counted.
- dram_wr_addr  in  32  word address of the burst's first word.
- dram_wr_data  in  32  write word, sampled in the cycle dram_wr_val=1.
- dram_wr_val  out  1  one-cycle pulse per accepted write word.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, async): state=IDLE; dram_rd_val=0, dram_wr_val=0, dram_rd_data=0, busy=0; beat and latency counters cleared.
  - Memory array is not reset; contents are preserved across reset.
- FSM states: IDLE, RD_WAIT, RD_BEAT, WR_WAIT, WR_BEAT, DONE.
- IDLE:
  - dram_wr_req=1 -> latch base=dram_wr_addr[MEM_AW-1:0] with the low log2(BLOCK_SIZE) bits forced to 0; go to WR_WAIT.
  - else dram_rd_req=1 -> latch the base from dram_rd_addr the same way; go to RD_WAIT.
  - Write has priority when both requests are high.
- RD_WAIT: count to RD_LATENCY-1, then RD_BEAT.
- RD_BEAT:
  - Registered outputs: dram_rd_val=1 and dram_rd_data=mem[base+beat] in the same cycle.
  - beat increments after each pulse.
  - Pulses are spaced BEAT_GAP+1 cycles apart.
  - After beat BLOCK_SIZE-1, go to DONE.
- WR_WAIT: count to WR_LATENCY-1, then WR_BEAT.
  - The requester registers its data one cycle after the request rises, hence WR_LATENCY>=2.
- WR_BEAT:
  - In each pulse cycle, dram_wr_val=1 and mem[base+beat] <= dram_wr_data.
  - Spaced BEAT_GAP+1 cycles apart, because the requester updates its data one cycle after each val.
  - After the last beat, go to DONE.
- DONE: no val pulses; return to IDLE when the request that started the burst is low.
  - Prevents re-triggering while the requester's counter is still settling.
- Address arithmetic: base+beat wraps modulo 2^MEM_AW. Address bits above MEM_AW-1 are ignored.
- Request dropped mid-burst (protocol violation): the burst is abandoned at the next beat boundary; go to IDLE. Words already written are kept.
- Reset mid-burst: outputs drop asynchronously. Completed write beats remain in memory.
- Throughput: one burst occupies RD_LATENCY or WR_LATENCY + BLOCK_SIZE*(BEAT_GAP+1) + DONE cycles.
  - A write-back followed immediately by dram_rd_req is accepted on the first IDLE cycle.

Optional Feature:
- Macro: DRAM_ALIGN_CHK_EN.
- Defined:
  - Adds output addr_err (1 bit, reset 0).
  - addr_err is set sticky when a request is latched with nonzero low log2(BLOCK_SIZE) address bits; it clears only on reset.
  - The burst is still served at the aligned base.
- Undefined: no addr_err port; low bits are silently masked.

Test Plan:
- Write burst, dram_wr_addr=0x40, requester-style data 0x1000..0x1007 updated one cycle after each val -> 8 dram_wr_val pulses:
  - first pulse WR_LATENCY cycles after the request is sampled;
  - pulses 2 cycles apart;
  - mem[0x40..0x47]=0x1000..0x1007.
- Read burst, dram_rd_addr=0x40 -> 8 dram_rd_val pulses with data 0x1000..0x1007 in order; first pulse 4 cycles after the request is sampled; busy high throughout.
- Requests held 3 cycles past the last beat -> no extra val pulses; IDLE is re-entered the cycle after the request falls.
- dram_wr_req and dram_rd_req rise together (wr addr 0x80, rd addr 0x40) -> the write completes first; the read follows immediately after the write request drops.
- rst_n low after the 3rd beat of a write to 0x100 -> dram_wr_val=0 and busy=0 immediately; mem[0x100..0x102] are updated and mem[0x103] is unchanged.
- With DRAM_ALIGN_CHK_EN, dram_rd_addr=0x43 -> addr_err=1 and stays high; data is returned from 0x40..0x47.

Source files
------------

// File: rtl/dram_ctrl_resp_if.sv
// dram_ctrl_resp_if
//   Burst interface between the data cache (master) and the DRAM responder (slave).
//   The cache raises a level request with a block-aligned word address. The
//   responder answers with one val pulse per word of the block.
//
//   Signals:
//     dram_rd_req   master->slave  read burst request (level, held for the whole burst)
//     dram_rd_addr  master->slave  word address of the first word of the read burst
//     dram_rd_data  slave->master  read word, valid while dram_rd_val=1
//     dram_rd_val   slave->master  one-cycle pulse per returned word
//     dram_wr_req   master->slave  write burst request (level, held for the whole burst)
//     dram_wr_addr  master->slave  word address of the first word of the write burst
//     dram_wr_data  master->slave  write word, sampled in the cycle dram_wr_val=1
//     dram_wr_val   slave->master  one-cycle pulse per accepted write word

interface dram_ctrl_resp_if;
    logic        dram_rd_req;
    logic [31:0] dram_rd_addr;
    logic [31:0] dram_rd_data;
    logic        dram_rd_val;
    logic        dram_wr_req;
    logic [31:0] dram_wr_addr;
    logic [31:0] dram_wr_data;
    logic        dram_wr_val;

    modport master (
        output dram_rd_req,
        output dram_rd_addr,
        input  dram_rd_data,
        input  dram_rd_val,
        output dram_wr_req,
        output dram_wr_addr,
        output dram_wr_data,
        input  dram_wr_val
    );

    modport slave (
        input  dram_rd_req,
        input  dram_rd_addr,
        output dram_rd_data,
        output dram_rd_val,
        input  dram_wr_req,
        input  dram_wr_addr,
        input  dram_wr_data,
        output dram_wr_val
    );
endinterface

// File: rtl/dram_ctrl_resp.sv
// dram_ctrl_resp
//   Single-port DRAM responder that sits behind the data cache's block-fill
//   and write-back port. It holds a 2^MEM_AW x 32-bit word-addressed memory and
//   serves BLOCK_SIZE-word bursts. A read burst starts RD_LATENCY cycles after the
//   request is sampled. A write burst starts WR_LATENCY cycles after the request
//   is sampled. Pulses within a burst are spaced BEAT_GAP+1 cycles apart.
//
//   Parameters:
//     MEM_AW      word-address bits indexing the internal memory
//     BLOCK_SIZE  words per burst (power of 2)
//     RD_LATENCY  request sample to first dram_rd_val, >= 1
//     WR_LATENCY  request sample to first dram_wr_val, >= 2
//     BEAT_GAP    idle cycles between pulses inside a burst, >= 1
//
//   Ports:
//     clock     system clock, rising edge
//     rst_n     asynchronous active-low reset (memory contents are not reset)
//     bus       dram_ctrl_resp_if.slave burst interface
//     addr_err  sticky misaligned-request flag (only with DRAM_ALIGN_CHK_EN)
//     busy      high whenever the responder is not idle
//
//   Build option:
//     DRAM_ALIGN_CHK_EN  adds the addr_err output. Without it, the low block-offset
//                        address bits are silently masked.

module dram_ctrl_resp #(
    parameter int MEM_AW     = 14,
    parameter int BLOCK_SIZE = 8,
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 2,
    parameter int BEAT_GAP   = 1
) (
    input  logic            clock,
    input  logic            rst_n,
    dram_ctrl_resp_if.slave bus,
`ifdef DRAM_ALIGN_CHK_EN
    output logic            addr_err,
`endif
    output logic            busy
);

    localparam int OFF_W     = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int CNT_W     = 16;
    localparam int MEM_DEPTH = 1 << MEM_AW;

    localparam logic [MEM_AW-1:0] OFF_MASK    = MEM_AW'(BLOCK_SIZE - 1);
    localparam logic [OFF_W-1:0]  LAST_BEAT   = OFF_W'(BLOCK_SIZE - 1);
    localparam logic [CNT_W-1:0]  RD_LAT_LAST = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0]  WR_LAT_LAST = CNT_W'(WR_LATENCY - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(BEAT_GAP);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BEAT,
        WR_WAIT,
        WR_BEAT,
        DONE
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  lat_cnt, lat_cnt_nx;
    logic [CNT_W-1:0]  gap_cnt, gap_cnt_nx;
    logic [OFF_W-1:0]  beat, beat_nx;
    logic [MEM_AW-1:0] base, base_nx;
    logic              burst_wr, burst_wr_nx;
    logic              rd_val_q, rd_val_nx;
    logic              wr_val_q, wr_val_nx;
    logic [31:0]       rd_data_q;
    logic              rd_load;
    logic              set_err;

    logic [MEM_AW-1:0] rd_base, wr_base;
    logic              rd_misaligned, wr_misaligned;
    logic [MEM_AW-1:0] rd_idx, wr_idx;
    logic              mem_we;
    logic              active_req;

    logic [31:0]       mem [MEM_DEPTH];

    // Address bits above MEM_AW-1 are dropped. The block offset is forced to zero,
    // so the burst always covers a whole aligned block.
    assign rd_base       = bus.dram_rd_addr[MEM_AW-1:0] & ~OFF_MASK;
    assign wr_base       = bus.dram_wr_addr[MEM_AW-1:0] & ~OFF_MASK;
    assign rd_misaligned = |(bus.dram_rd_addr[MEM_AW-1:0] & OFF_MASK);
    assign wr_misaligned = |(bus.dram_wr_addr[MEM_AW-1:0] & OFF_MASK);

    // DONE waits only on the request that opened the burst. Because of this, a
    // read held behind a write-back is picked up on the first IDLE cycle.
    assign active_req = burst_wr ? bus.dram_wr_req : bus.dram_rd_req;

    // The read word is fetched for the beat about to be pulsed. The write lands
    // at the beat currently being pulsed. Both indices wrap modulo 2^MEM_AW.
    assign rd_idx = base + MEM_AW'(beat_nx);
    assign wr_idx = base + MEM_AW'(beat);
    assign mem_we = (state == WR_BEAT) && wr_val_q;

    // Next-state logic. A pulse is issued from the cycle where the latency or gap
    // counter reaches its end. If the request has fallen by then, the burst is abandoned.
    always_comb begin
        state_nx    = state;
        lat_cnt_nx  = lat_cnt;
        gap_cnt_nx  = gap_cnt;
        beat_nx     = beat;
        base_nx     = base;
        burst_wr_nx = burst_wr;
        rd_val_nx   = 1'b0;
        wr_val_nx   = 1'b0;
        rd_load     = 1'b0;
        set_err     = 1'b0;

        case (state)
            IDLE: begin
                lat_cnt_nx = '0;
                gap_cnt_nx = '0;
                beat_nx    = '0;
                if (bus.dram_wr_req) begin
                    base_nx     = wr_base;
                    burst_wr_nx = 1'b1;
                    set_err     = wr_misaligned;
                    state_nx    = WR_WAIT;
                end else if (bus.dram_rd_req) begin
                    base_nx     = rd_base;
                    burst_wr_nx = 1'b0;
                    set_err     = rd_misaligned;
                    state_nx    = RD_WAIT;
                end
            end

            RD_WAIT: begin
                if (lat_cnt == RD_LAT_LAST) begin
                    if (!bus.dram_rd_req) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx  = RD_BEAT;
                        rd_val_nx = 1'b1;
                        rd_load   = 1'b1;
                    end
                end else begin
                    lat_cnt_nx = lat_cnt + CNT_W'(1);
                end
            end

            RD_BEAT: begin
                if (gap_cnt == GAP_LAST) begin
                    if (beat == LAST_BEAT) begin
                        state_nx = DONE;
                    end else if (!bus.dram_rd_req) begin
                        state_nx = IDLE;
                    end else begin
                        beat_nx    = beat + OFF_W'(1);
                        gap_cnt_nx = '0;
                        rd_val_nx  = 1'b1;
                        rd_load    = 1'b1;
                    end
                end else begin
                    gap_cnt_nx = gap_cnt + CNT_W'(1);
                end
            end

            WR_WAIT: begin
                if (lat_cnt == WR_LAT_LAST) begin
                    if (!bus.dram_wr_req) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx  = WR_BEAT;
                        wr_val_nx = 1'b1;
                    end
                end else begin
                    lat_cnt_nx = lat_cnt + CNT_W'(1);
                end
            end

            WR_BEAT: begin
                if (gap_cnt == GAP_LAST) begin
                    if (beat == LAST_BEAT) begin
                        state_nx = DONE;
                    end else if (!bus.dram_wr_req) begin
                        state_nx = IDLE;
                    end else begin
                        beat_nx    = beat + OFF_W'(1);
                        gap_cnt_nx = '0;
                        wr_val_nx  = 1'b1;
                    end
                end else begin
                    gap_cnt_nx = gap_cnt + CNT_W'(1);
                end
            end

            DONE: begin
                if (!active_req) begin
                    state_nx = IDLE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, counters and registered burst outputs. Asserting reset drops
    // the val pulses and busy immediately.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            gap_cnt   <= '0;
            beat      <= '0;
            base      <= '0;
            burst_wr  <= 1'b0;
            rd_val_q  <= 1'b0;
            wr_val_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state    <= state_nx;
            lat_cnt  <= lat_cnt_nx;
            gap_cnt  <= gap_cnt_nx;
            beat     <= beat_nx;
            base     <= base_nx;
            burst_wr <= burst_wr_nx;
            rd_val_q <= rd_val_nx;
            wr_val_q <= wr_val_nx;
            if (rd_load) begin
                rd_data_q <= mem[rd_idx];
            end
        end
    end

    // The memory array has no reset, so contents survive a reset. The write
    // enable derives from the state register. Therefore a reset inside a pulse
    // cycle suppresses that beat's write.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[wr_idx] <= bus.dram_wr_data;
        end
    end

`ifdef DRAM_ALIGN_CHK_EN
    // Sticky flag: once set by a misaligned request, only reset clears it.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else if (set_err) begin
            addr_err <= 1'b1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{bus.dram_rd_addr[31:MEM_AW], bus.dram_wr_addr[31:MEM_AW]};
`else
    logic unused_bits;
    assign unused_bits = ^{bus.dram_rd_addr[31:MEM_AW], bus.dram_wr_addr[31:MEM_AW], set_err};
`endif

    assign bus.dram_rd_val  = rd_val_q;
    assign bus.dram_rd_data = rd_data_q;
    assign bus.dram_wr_val  = wr_val_q;
    assign busy             = (state != IDLE);

endmodule

// File: tb/tb_dram_ctrl_resp.sv
// tb_dram_ctrl_resp
//   Directed bench for dram_ctrl_resp with default parameters (MEM_AW=14, 8-word
//   blocks, read latency 4, write latency 2, beat gap 1). A requester model in the
//   tasks acts like the cache. It holds the request, updates write data one
//   cycle after each val, and drops the request a chosen number of cycles after
//   the last beat. Cycle k is the cycle that follows the k-th rising edge after
//   the request is first presented. Outputs are sampled on the falling edge.
//   Compiles with or without DRAM_ALIGN_CHK_EN.

module tb_dram_ctrl_resp;

    localparam int MEM_AW     = 14;
    localparam int BLOCK_SIZE = 8;
    localparam int RD_LATENCY = 4;
    localparam int WR_LATENCY = 2;
    localparam int BEAT_GAP   = 1;

    logic clock = 1'b0;
    logic rst_n;
    logic busy;
`ifdef DRAM_ALIGN_CHK_EN
    logic addr_err;
`endif

    int check_count = 0;
    int fail_count  = 0;

    logic [31:0] exp_words [BLOCK_SIZE];

    dram_ctrl_resp_if bus();

    dram_ctrl_resp #(
        .MEM_AW     (MEM_AW),
        .BLOCK_SIZE (BLOCK_SIZE),
        .RD_LATENCY (RD_LATENCY),
        .WR_LATENCY (WR_LATENCY),
        .BEAT_GAP   (BEAT_GAP)
    ) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .bus      (bus),
`ifdef DRAM_ALIGN_CHK_EN
        .addr_err (addr_err),
`endif
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd_req, input logic [31:0] rd_addr,
                                 input logic wr_req, input logic [31:0] wr_addr,
                                 input logic [31:0] wr_data);
        bus.dram_rd_req  = rd_req;
        bus.dram_rd_addr = rd_addr;
        bus.dram_wr_req  = wr_req;
        bus.dram_wr_addr = wr_addr;
        bus.dram_wr_data = wr_data;
    endtask

    task automatic fillWords(input logic [31:0] first);
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            exp_words[i] = first + 32'(i);
        end
    endtask

    // Runs one burst as the cache would. For a write, it supplies exp_words. For
    // a read, it expects exp_words back. The first pulse is expected in cycle exp_first.
    task automatic runBurst(input string name, input bit is_wr, input logic [31:0] addr,
                            input int exp_first, input int hold, input bit chk_idle);
        int   pulses    = 0;
        int   first     = -1;
        int   last      = -1;
        int   drop_cyc  = -1;
        int   gap_bad   = 0;
        int   data_bad  = 0;
        int   busy_low  = 0;
        int   other_val = 0;
        logic busy_at_drop = 1'b0;
        logic busy_after   = 1'b1;
        logic cur_val;
        logic done = 1'b0;

        if (is_wr) begin
            bus.dram_wr_req  = 1'b1;
            bus.dram_wr_addr = addr;
            bus.dram_wr_data = 32'hDEAD_BEEF;
        end else begin
            bus.dram_rd_req  = 1'b1;
            bus.dram_rd_addr = addr;
        end

        for (int k = 0; k < 200 && !done; k++) begin
            @(posedge clock);
            #1;
            if (is_wr && pulses < BLOCK_SIZE) begin
                bus.dram_wr_data = exp_words[pulses];
            end
            if (drop_cyc < 0 && pulses == BLOCK_SIZE && k >= last + 1 + hold) begin
                if (is_wr) bus.dram_wr_req = 1'b0;
                else       bus.dram_rd_req = 1'b0;
                drop_cyc = k;
            end

            @(negedge clock);
            cur_val = is_wr ? bus.dram_wr_val : bus.dram_rd_val;
            if (is_wr ? bus.dram_rd_val : bus.dram_wr_val) other_val++;
            if (cur_val) begin
                if (first < 0) first = k;
                else if (k - last != BEAT_GAP + 1) gap_bad++;
                if (!is_wr && pulses < BLOCK_SIZE && bus.dram_rd_data !== exp_words[pulses]) data_bad++;
                pulses++;
                last = k;
            end
            if (first >= 0 && drop_cyc < 0 && !busy) busy_low++;
            if (k == drop_cyc) busy_at_drop = busy;
            if (drop_cyc >= 0 && k == drop_cyc + 1) begin
                busy_after = busy;
                done = 1'b1;
            end
        end

        checkOutput({name, "_done"},      32'(done),      32'd1);
        checkOutput({name, "_first"},     32'(first),     32'(exp_first));
        checkOutput({name, "_pulses"},    32'(pulses),    32'(BLOCK_SIZE));
        checkOutput({name, "_gap"},       32'(gap_bad),   32'd0);
        checkOutput({name, "_busy"},      32'(busy_low),  32'd0);
        checkOutput({name, "_other_val"}, 32'(other_val), 32'd0);
        if (!is_wr) checkOutput({name, "_data"}, 32'(data_bad), 32'd0);
        if (chk_idle) begin
            checkOutput({name, "_done_busy"}, 32'(busy_at_drop), 32'd1);
            checkOutput({name, "_idle_after"}, 32'(busy_after), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", check_count);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;

        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_rd_val",  32'(bus.dram_rd_val), 32'd0);
        checkOutput("rst_wr_val",  32'(bus.dram_wr_val), 32'd0);
        checkOutput("rst_rd_data", bus.dram_rd_data,     32'd0);
        checkOutput("rst_busy",    32'(busy),            32'd0);
`ifdef DRAM_ALIGN_CHK_EN
        checkOutput("rst_addr_err", 32'(addr_err), 32'd0);
`endif
        @(posedge clock);
        #1 rst_n = 1'b1;
        @(negedge clock);

        $display("[TB] write burst to 0x40");
        fillWords(32'h1000);
        runBurst("wr40", 1'b1, 32'h40, WR_LATENCY, 3, 1'b1);

        $display("[TB] read burst from 0x40");
        runBurst("rd40", 1'b0, 32'h40, RD_LATENCY, 3, 1'b1);

        $display("[TB] write burst to 0x100");
        fillWords(32'h2000);
        runBurst("wr100", 1'b1, 32'h100, WR_LATENCY, 1, 1'b1);

        // Both requests rise together. The write wins, and the read is accepted on
        // the first IDLE cycle after the write's DONE. That is one cycle later
        // than a read started from IDLE.
        $display("[TB] simultaneous write 0x80 and read 0x40");
        fillWords(32'h4000);
        bus.dram_rd_req  = 1'b1;
        bus.dram_rd_addr = 32'h40;
        runBurst("both_wr", 1'b1, 32'h80, WR_LATENCY, 0, 1'b0);
        fillWords(32'h1000);
        runBurst("both_rd", 1'b0, 32'h40, RD_LATENCY + 1, 1, 1'b1);

        fillWords(32'h4000);
        runBurst("rd80", 1'b0, 32'h80, RD_LATENCY, 1, 1'b1);

        $display("[TB] reset during write burst to 0x100");
        fillWords(32'h3000);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h100, 32'hDEAD_BEEF);
        pulses = 0;
        for (int k = 0; k < 50 && pulses < 3; k++) begin
            @(posedge clock);
            #1 bus.dram_wr_data = exp_words[pulses];
            @(negedge clock);
            if (bus.dram_wr_val) pulses++;
        end
        checkOutput("rst_mid_pulses", 32'(pulses), 32'd3);
        @(posedge clock);
        #1 bus.dram_wr_data = exp_words[3];
        @(posedge clock);
        #1;
        checkOutput("rst_mid_pre_val", 32'(bus.dram_wr_val), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_wr_val", 32'(bus.dram_wr_val), 32'd0);
        checkOutput("rst_mid_busy",   32'(busy),            32'd0);
        bus.dram_wr_req = 1'b0;
        @(posedge clock);
        #1 rst_n = 1'b1;
        @(negedge clock);

        // Three beats of the interrupted burst landed; the rest is the earlier block.
        fillWords(32'h2000);
        exp_words[0] = 32'h3000;
        exp_words[1] = 32'h3001;
        exp_words[2] = 32'h3002;
        runBurst("rd100", 1'b0, 32'h100, RD_LATENCY, 1, 1'b1);

        $display("[TB] misaligned read 0x43 and high-bit read 0xFFFFC040");
        fillWords(32'h1000);
        runBurst("rd43", 1'b0, 32'h43, RD_LATENCY, 1, 1'b1);
`ifdef DRAM_ALIGN_CHK_EN
        checkOutput("addr_err_set", 32'(addr_err), 32'd1);
`endif
        runBurst("rdhi", 1'b0, 32'hFFFF_C040, RD_LATENCY, 1, 1'b1);
`ifdef DRAM_ALIGN_CHK_EN
        checkOutput("addr_err_sticky", 32'(addr_err), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
